// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port data RAM between the instruction-
// fetch port (i_*) and the load/store port (d_*). One word access at a time:
// IDLE picks a winner, ACCESS holds the RAM strobes for WAIT_CYCLES cycles,
// DONE pulses the owner's ack for one cycle.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: simultaneous requests alternate
// between the ports instead of the data port always winning.
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_data_out
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic {OWN_D = 1'b0, OWN_I = 1'b1} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, grant_sel;
  logic              grant_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [31:0]       lat_wdata;
  logic              lat_err;
  logic              in_access, in_done, capture;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_served;

  // Winner select: on a tie, grant the port that was not served last.
  always_comb begin
    grant_sel = OWN_D;
    if (i_req && d_req) grant_sel = (last_served == OWN_D) ? OWN_I : OWN_D;
    else if (i_req)     grant_sel = OWN_I;
  end

  // Remember who got the most recent grant.
  always_ff @(posedge clk) begin
    if (reset)          last_served <= OWN_D;
    else if (grant_vld) last_served <= grant_sel;
  end
`else
  // Winner select: the data port wins every tie.
  always_comb begin
    grant_sel = d_req ? OWN_D : OWN_I;
  end
`endif

  assign grant_vld = (state == S_IDLE) && (i_req || d_req);
  assign sel_addr  = (grant_sel == OWN_I) ? i_addr : d_addr;
  assign in_access = (state == S_ACCESS);
  assign in_done   = (state == S_DONE);
  assign capture   = in_access && (cnt == '0) && !lat_we;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; misaligned requests skip the RAM and go straight to DONE.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (i_req || d_req)
                  state_nxt = (sel_addr[1:0] != 2'b00) ? S_DONE : S_ACCESS;
      S_ACCESS: if (cnt == '0) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Latch the winning request at grant and count down the access cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_D;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_err   <= 1'b0;
    end else if (grant_vld) begin
      owner     <= grant_sel;
      lat_addr  <= sel_addr;
      lat_we    <= (grant_sel == OWN_D) && d_we;
      lat_wdata <= (grant_sel == OWN_D) ? d_wdata : '0;
      lat_err   <= (sel_addr[1:0] != 2'b00);
      cnt       <= CNT_W'(WAIT_CYCLES - 1);
    end else if (in_access && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Capture read data into the owner's register on the last access cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (capture) begin
      if (owner == OWN_I) i_rdata <= mem_data_out;
      else                d_rdata <= mem_data_out;
    end
  end

  // RAM strobes only in ACCESS; address and data forced to 0 elsewhere.
  assign mem_read    = in_access && !lat_we;
  assign mem_write   = in_access && lat_we;
  assign mem_addr    = in_access ? lat_addr  : '0;
  assign mem_data_in = in_access ? lat_wdata : '0;

  assign i_ack = in_done && (owner == OWN_I);
  assign d_ack = in_done && (owner == OWN_D);
  assign i_err = i_ack && lat_err;
  assign d_err = d_ack && lat_err;

endmodule
